// File: rtl/sram_bus_pkg.sv
// Shared types for the SRAM bus arbiter: sequencer states, owner encoding, protected address.
// Combinational only; no latency or backpressure of its own.
package sram_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LATCH,
        RD_OE,
        RD_CAP,
        WR_DATA,
        WR_PULSE,
        DONE
    } state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    localparam logic [7:0] NOWRITE_ADDR_DEF = 8'hFF;

    // The SRAM owns the data pins exactly in these two states.
    function automatic logic sram_drives_bus(input state_t s);
        return (s == RD_OE) || (s == RD_CAP);
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_if.sv
// Requester handshakes plus external SRAM pins; slave = arbiter, master = requesters/board side.
// Signal bundle only; no latency or backpressure of its own.
interface sram_bus_arbiter_if #(
    parameter int W = 8
);
    logic         c_req;
    logic         c_we;
    logic [W-1:0] c_addr;
    logic [W-1:0] c_wdata;
    logic         c_done;
    logic [W-1:0] c_rdata;

    logic         h_req;
    logic         h_we;
    logic [W-1:0] h_addr;
    logic [W-1:0] h_wdata;
    logic         h_done;
    logic [W-1:0] h_rdata;

    logic [W-1:0] bus_in;
    logic [W-1:0] bus_out;
    logic [W-1:0] bus_oe;
    logic         latch_le;
    logic         mem_oe_n;
    logic         mem_we_n;
    logic         busy;
    logic         owner;

    modport master (
        output c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, bus_in,
        input  c_done, c_rdata, h_done, h_rdata,
        input  bus_out, bus_oe, latch_le, mem_oe_n, mem_we_n, busy, owner
    );

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, bus_in,
        output c_done, c_rdata, h_done, h_rdata,
        output bus_out, bus_oe, latch_le, mem_oe_n, mem_we_n, busy, owner
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-served pointer moves on accept.
// Grant is same-cycle; no backpressure, the caller decides when to accept.
module rr_arbiter2
    import sram_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       last
);

    // bit 0 = core, bit 1 = host; on a tie the port not served last wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWN_HOST) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset pretends the host was served last so the core wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= OWN_HOST;
        end else if (accept) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Owns the shared SRAM address/data bus and sequences latch/read/write strobes for core or host.
// Read done 5 cycles after accept, write 4+WE_CYCLES, protected write 4; requests wait in IDLE while busy.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int           W            = 8,
    parameter int           WE_CYCLES    = 1,
    parameter logic [W-1:0] NOWRITE_ADDR = W'(NOWRITE_ADDR_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    sram_bus_arbiter_if.slave  bus
);

    state_t       st;
    state_t       st_nxt;

    logic         acc_we;
    logic [W-1:0] acc_addr;
    logic [W-1:0] acc_wdata;
    logic         own;
    logic [W:0]   we_cnt;
    logic [W-1:0] bus_out_q;
    logic [W-1:0] c_rdata_q;
    logic [W-1:0] h_rdata_q;

    logic [1:0]   gnt;
    logic         last_served;
    logic         accept;
    logic         sel_we;
    logic [W-1:0] sel_addr;
    logic [W-1:0] sel_wdata;

    assign accept = (st == IDLE) && (bus.c_req || bus.h_req);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    ({bus.h_req, bus.c_req}),
        .accept (accept),
        .gnt    (gnt),
        .last   (last_served)
    );

    always_comb begin
        st_nxt    = st;
        sel_we    = gnt[1] ? bus.h_we    : bus.c_we;
        sel_addr  = gnt[1] ? bus.h_addr  : bus.c_addr;
        sel_wdata = gnt[1] ? bus.h_wdata : bus.c_wdata;

        case (st)
            IDLE:     if (accept) st_nxt = ADDR;
            ADDR:     st_nxt = LATCH;
            LATCH:    st_nxt = acc_we ? WR_DATA : RD_OE;
            RD_OE:    st_nxt = RD_CAP;
            RD_CAP:   st_nxt = DONE;
            WR_DATA:  st_nxt = (acc_addr == NOWRITE_ADDR) ? DONE : WR_PULSE;
            WR_PULSE: if (we_cnt == (W+1)'(WE_CYCLES - 1)) st_nxt = DONE;
            DONE:     st_nxt = IDLE;
            default:  st_nxt = IDLE;
        endcase

        // Every pin is a decode of state or a register; nothing passes straight from an input.
        bus.busy     = (st != IDLE);
        bus.owner    = own;
        bus.latch_le = (st == ADDR);
        bus.mem_oe_n = !sram_drives_bus(st);
        bus.bus_oe   = sram_drives_bus(st) ? '0 : '1;
        bus.mem_we_n = (st != WR_PULSE);
        bus.bus_out  = bus_out_q;
        bus.c_done   = (st == DONE) && (own == OWN_CORE);
        bus.h_done   = (st == DONE) && (own == OWN_HOST);
        bus.c_rdata  = c_rdata_q;
        bus.h_rdata  = h_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // bus_out is loaded at the edge entering ADDR / WR_DATA and otherwise held,
    // which gives the address hold in LATCH and the data hold in DONE for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_we    <= 1'b0;
            acc_addr  <= '0;
            acc_wdata <= '0;
            own       <= OWN_CORE;
            bus_out_q <= '0;
            we_cnt    <= '0;
        end else begin
            if (accept) begin
                acc_we    <= sel_we;
                acc_addr  <= sel_addr;
                acc_wdata <= sel_wdata;
                own       <= gnt[1];
                bus_out_q <= sel_addr;
            end else if (st == LATCH && acc_we) begin
                bus_out_q <= acc_wdata;
            end

            if (st == WR_DATA) begin
                we_cnt <= '0;
            end else if (st == WR_PULSE) begin
                we_cnt <= we_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_rdata_q <= '0;
            h_rdata_q <= '0;
        end else if (st == RD_CAP) begin
            if (own == OWN_HOST) begin
                h_rdata_q <= bus.bus_in;
            end else begin
                c_rdata_q <= bus.bus_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a latch+SRAM model on the pins.
// Checks latency, strobe shapes, rdata routing, round-robin order, async reset and pin invariants.
module tb_sram_bus_arbiter;
    import sram_bus_pkg::*;

    localparam int W      = 8;
    localparam int WE_CYC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.W(W)) bus ();

    sram_bus_arbiter #(
        .W            (W),
        .WE_CYCLES    (WE_CYC),
        .NOWRITE_ADDR (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Board model: address latch closes at the end of the latch_le cycle, SRAM writes while WE low.
    logic [7:0] mem [256];
    logic [7:0] lat = 8'h00;
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = 8'h00;
    logic [7:0] pre_dat = 8'h00;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_dat;
        else if (!bus.mem_we_n) mem[lat] <= bus.bus_out;
        if (bus.latch_le) lat <= bus.bus_out;
    end

    assign bus.bus_in = (!bus.mem_oe_n && bus.bus_oe == 8'h00) ? mem[lat] : 8'h00;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("inv_oe_we_both_low", {31'd0, (!bus.mem_oe_n && !bus.mem_we_n)}, 32'd0);
            chk("inv_oe_dir_pair", {31'd0, ((bus.bus_oe == 8'h00) != !bus.mem_oe_n)}, 32'd0);
            chk("inv_two_done", {31'd0, (bus.c_done && bus.h_done)}, 32'd0);
        end
    end

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_dat = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // k=0 is the IDLE cycle that samples req; done_k is the cycle index of the done pulse.
    task automatic txn(input bit host, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                       output int done_k, output int le_n, output int oe_cyc, output int we_cyc,
                       output logic [7:0] le_addr, output logic [7:0] we_dat);
        done_k = -1; le_n = 0; oe_cyc = 0; we_cyc = 0; le_addr = 8'h00; we_dat = 8'h00;
        @(posedge clk); #1;
        if (host) begin
            bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = addr; bus.h_wdata = wdata;
        end else begin
            bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.latch_le) begin le_n++; le_addr = bus.bus_out; end
            if (!bus.mem_oe_n && bus.bus_oe == 8'h00) oe_cyc++;
            if (!bus.mem_we_n) begin we_cyc++; we_dat = bus.bus_out; end
            if (host ? bus.h_done : bus.c_done) begin done_k = k; break; end
        end
        bus.c_req = 1'b0;
        bus.h_req = 1'b0;
    endtask

    int         dk, le, oe, wc;
    logic [7:0] la, wd;
    int         order [4];
    int         own_seq [4];
    int         le_k [4];
    int         done_at [4];
    int         nd, nl;
    bit         saw_we;

    initial begin
        reset = 1'b1;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_wdata = 0;
        #23;
        chk("rst_busy",     {31'd0, bus.busy},     32'd0);
        chk("rst_bus_oe",   {24'd0, bus.bus_oe},   32'hFF);
        chk("rst_oe_n",     {31'd0, bus.mem_oe_n}, 32'd1);
        chk("rst_we_n",     {31'd0, bus.mem_we_n}, 32'd1);
        chk("rst_latch_le", {31'd0, bus.latch_le}, 32'd0);
        chk("rst_bus_out",  {24'd0, bus.bus_out},  32'd0);
        chk("rst_owner",    {31'd0, bus.owner},    32'd0);
        chk("rst_c_rdata",  {24'd0, bus.c_rdata},  32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        preload(8'h10, 8'h5A);
        preload(8'hFF, 8'hAA);

        // core read
        txn(1'b0, 1'b0, 8'h10, 8'h00, dk, le, oe, wc, la, wd);
        chk("rd_done_k",   dk, 5);
        chk("rd_le_cycles", le, 1);
        chk("rd_le_addr",  {24'd0, la}, 32'h10);
        chk("rd_oe_cycles", oe, 2);
        chk("rd_we_cycles", wc, 0);
        chk("rd_c_rdata",  {24'd0, bus.c_rdata}, 32'h5A);
        chk("rd_h_rdata",  {24'd0, bus.h_rdata}, 32'h00);
        @(negedge clk);
        chk("rd_c_rdata_hold", {24'd0, bus.c_rdata}, 32'h5A);
        chk("rd_idle_busy",    {31'd0, bus.busy},    32'd0);

        // host write
        txn(1'b1, 1'b1, 8'h20, 8'hC3, dk, le, oe, wc, la, wd);
        chk("wr_done_k",    dk, 4 + WE_CYC);
        chk("wr_we_cycles", wc, WE_CYC);
        chk("wr_we_data",   {24'd0, wd}, 32'hC3);
        chk("wr_oe_cycles", oe, 0);
        chk("wr_mem",       {24'd0, mem[8'h20]}, 32'hC3);
        chk("wr_c_rdata_untouched", {24'd0, bus.c_rdata}, 32'h5A);

        // protected write
        txn(1'b0, 1'b1, 8'hFF, 8'h01, dk, le, oe, wc, la, wd);
        chk("pw_done_k",    dk, 4);
        chk("pw_we_cycles", wc, 0);
        chk("pw_mem",       {24'd0, mem[8'hFF]}, 32'hAA);

        // host read back, core rdata must stay put
        txn(1'b1, 1'b0, 8'h20, 8'h00, dk, le, oe, wc, la, wd);
        chk("hr_done_k",  dk, 5);
        chk("hr_h_rdata", {24'd0, bus.h_rdata}, 32'hC3);
        chk("hr_c_rdata", {24'd0, bus.c_rdata}, 32'h5A);

        // contention: both requesting from reset
        @(negedge clk);
        reset = 1'b1;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h10;
        bus.h_req = 1; bus.h_we = 0; bus.h_addr = 8'h20;
        @(posedge clk); #1;
        chk("ct_rst_c_rdata", {24'd0, bus.c_rdata}, 32'h00);
        reset = 1'b0;
        nd = 0; nl = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            @(negedge clk);
            if (bus.latch_le && nl < 4) begin own_seq[nl] = bus.owner; le_k[nl] = k; nl++; end
            if (bus.c_done || bus.h_done) begin
                order[nd] = bus.h_done ? 1 : 0;
                done_at[nd] = k;
                nd++;
            end
        end
        bus.c_req = 0; bus.h_req = 0;
        chk("ct_n_done", nd, 4);
        chk("ct_n_addr", nl, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ct_grant%0d", i), order[i], i % 2);
            chk($sformatf("ct_owner%0d", i), own_seq[i], i % 2);
        end
        chk("ct_first_addr_k", le_k[0], 1);
        chk("ct_gap", le_k[1] - done_at[0], 2);
        chk("ct_c_rdata", {24'd0, bus.c_rdata}, 32'h5A);
        chk("ct_h_rdata", {24'd0, bus.h_rdata}, 32'hC3);

        // reset in the middle of the WE pulse
        @(posedge clk); #1;
        bus.c_req = 1; bus.c_we = 1; bus.c_addr = 8'h30; bus.c_wdata = 8'h77;
        saw_we = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus.mem_we_n) begin saw_we = 1; break; end
        end
        chk("mr_saw_we", {31'd0, saw_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_we_n",  {31'd0, bus.mem_we_n}, 32'd1);
        chk("mr_bus_oe", {24'd0, bus.bus_oe},  32'hFF);
        chk("mr_busy",  {31'd0, bus.busy},     32'd0);
        chk("mr_done",  {31'd0, bus.c_done},   32'd0);
        bus.c_req = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mr_no_done", {31'd0, (bus.c_done || bus.h_done)}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        txn(1'b0, 1'b0, 8'h10, 8'h00, dk, le, oe, wc, la, wd);
        chk("mr_rd_done_k", dk, 5);
        chk("mr_rd_le_addr", {24'd0, la}, 32'h10);
        chk("mr_rd_c_rdata", {24'd0, bus.c_rdata}, 32'h5A);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Owns the shared 8-bit external SRAM bus: address latch, OE/WE strobes and bidirectional data pins.
- Arbitrates between two requesters: port C (SUBNEG core) and port H (host loader/debug).
- Runs the latch-address / read / write strobe sequence for the granted port, so neither requester drives pins directly.

Parameters:
- W, 8, address and data width (address and data share the bus, so they are equal).
- WE_CYCLES, 1, number of cycles mem_we_n is held low (1..4).
- NOWRITE_ADDR, 8'hFF, write-protected address: the write handshake completes with no WE pulse.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- c_req  in  1  core request, level
- c_we  in  1  core 1=write, 0=read
- c_addr  in  W  core address
- c_wdata  in  W  core write data
- c_done  out  1  core completion pulse
- c_rdata  out  W  core read data
- h_req, h_we, h_addr, h_wdata  in  1/1/W/W  host equivalents
- h_done  out  1  host completion pulse
- h_rdata  out  W  host read data
- bus_in  in  W  SRAM/latch data pins, input path
- bus_out  out  W  data pins, output path
- bus_oe  out  W  pin direction, all-ones=drive, all-zeros=input
- latch_le  out  1  address latch enable, 1=transparent
- mem_oe_n  out  1  SRAM output enable, active low
- mem_we_n  out  1  SRAM write enable, active low
- busy  out  1  transaction in progress
- owner  out  1  0=core, 1=host; valid while busy

Behaviour:
- Reset (async, immediate, including mid-transaction): state=IDLE, latch_le=0, mem_oe_n=1, mem_we_n=1, bus_oe=all ones, bus_out=0, done outputs=0, rdata outputs=0, busy=0, owner=0, round-robin pointer favours core.
- Moore outputs: every output is decoded from registered state or registers. There is no combinational path from any input to any output.
- Requests are levels, sampled only in IDLE. On accept, we/addr/wdata are captured into internal registers; later input changes are ignored.
- Arbitration in IDLE:
  - Only one req high: grant that port.
  - Both high: grant the port not served last (round-robin).
  - Neither high: stay in IDLE.
- States and outputs (signals not listed keep their IDLE values):
  - IDLE: busy=0, bus_oe=all ones, latch_le=0.
  - ADDR (1 cycle): latch_le=1, bus_out=addr, busy=1.
  - LATCH (1 cycle): latch_le=0, bus_out=addr held. Next state is RD_OE if read, WR_DATA if write.
  - RD_OE (1 cycle): bus_oe=0, mem_oe_n=0.
  - RD_CAP (1 cycle): bus_oe=0, mem_oe_n=0. bus_in is captured into the owner's rdata at the exit edge.
  - WR_DATA (1 cycle): bus_out=wdata, mem_oe_n=1. Next state is DONE if addr==NOWRITE_ADDR, otherwise WR_PULSE.
  - WR_PULSE (WE_CYCLES cycles, counter): mem_we_n=0, bus_out=wdata.
  - DONE (1 cycle): mem_we_n=1, mem_oe_n=1, bus_oe=all ones, bus_out holds its last value (data hold after WE rises). Owner's done=1 for exactly this cycle, then IDLE.
- Bus contention rule: bus_oe=0 and mem_oe_n=0 always coincide. mem_oe_n and mem_we_n are never low together.
- Latency from the IDLE cycle that samples req to done:
  - Read: 5 cycles.
  - Write: 4+WE_CYCLES cycles.
  - Protected write: 4 cycles.
- Throughput: the minimum gap is one IDLE cycle between transactions.
- rdata is valid in the done cycle and holds until that port's next read completes. The other port's rdata is untouched.
- A req still high in the IDLE cycle after DONE is a new request. Requesters drop req in the done cycle to avoid a repeat.
- The round-robin pointer updates only on accept.
- W+1-bit WE counter; no wrap concerns at WE_CYCLES ≤ 4.

Decomposition:
- Package sram_bus_pkg holds:
  - state enum (IDLE, ADDR, LATCH, RD_OE, RD_CAP, WR_DATA, WR_PULSE, DONE);
  - owner constants OWN_CORE=0 and OWN_HOST=1;
  - default NOWRITE_ADDR.
- One sub-module: rr_arbiter2.
  - Inputs: two reqs, an accept strobe.
  - Outputs: a one-hot grant and a last-served pointer.
- The sequencer FSM stays in sram_bus_arbiter.

Test Plan:
- Core read: c_req=1, c_we=0, c_addr=8'h10, SRAM model returns 8'h5A.
  - Expect: latch_le high for 1 cycle with bus_out=8'h10, then mem_oe_n low for 2 cycles with bus_oe=0.
  - Expect: c_done pulse 5 cycles after sampling, c_rdata=8'h5A, h_rdata still 0.
- Host write: h_addr=8'h20, h_wdata=8'hC3, WE_CYCLES=2.
  - Expect: mem_we_n low for exactly 2 cycles with bus_out=8'hC3, h_done at cycle 6, SRAM model[8'h20]=8'hC3.
- Protected write: c_we=1, c_addr=8'hFF, c_wdata=8'h01.
  - Expect: mem_we_n never low, c_done at cycle 4, SRAM model unchanged.
- Contention: c_req and h_req both held high from reset for 4 transactions.
  - Expect: grant order C, H, C, H; owner toggles; no two done pulses in the same cycle.
- Reset mid-write: assert reset while in WR_PULSE.
  - Expect: mem_we_n=1, bus_oe=all ones, busy=0 in the same cycle; no done pulse; a fresh read after release behaves normally.
- Invariant checker (all tests): never (mem_oe_n==0 and mem_we_n==0); never (bus_oe!=0 and mem_oe_n==0).
